uncached_data_bridge: RTL and testbench
=======================================

# uncached_data_bridge

Converts the CPU core's SRAM-like data port (`data_req`/`data_addr_ok`/`data_data_ok`) into single-beat AXI reads and writes for uncached accesses. Sits directly downstream of the core's data port, between the core and the SoC AXI crossbar. Keeps exactly one transaction outstanding and returns completion to the core with a registered one-cycle `data_data_ok` pulse.

## Interface

Parameters:
- None.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data_req` in 1: core request valid.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_size` in 3: 0 = byte, 1 = half, 2 = word; forwarded unchanged (3–7 unsupported).
- `data_wstrb` in 4: write byte strobes.
- `data_addr` in 32: physical address, forwarded unaligned-as-is.
- `data_wdata` in 32: write data.
- `data_addr_ok` out 1: request accepted this cycle.
- `data_data_ok` out 1: one-cycle completion pulse.
- `data_rdata` out 32: read data, valid while `data_data_ok` is high and held until the next read completes.
- `araddr` out 32: read address.
- `arsize` out 3: read size.
- `arvalid` out 1: read address valid.
- `arready` in 1: read address ready.
- `rdata` in 32: read data.
- `rvalid` in 1: read data valid.
- `rready` out 1: read data ready.
- `awaddr` out 32: write address.
- `awsize` out 3: write size.
- `awvalid` out 1: write address valid.
- `awready` in 1: write address ready.
- `wdata` out 32: write data.
- `wstrb` out 4: write strobes.
- `wvalid` out 1: write data valid.
- `wready` in 1: write data ready.
- `bvalid` in 1: write response valid.
- `bready` out 1: write response ready.

## Operation

- States: `IDLE`, `RD_AR`, `RD_R`, `WR_REQ`, `WR_B`.
- `IDLE`:
  - `data_addr_ok = data_req`, combinational.
  - On acceptance, latch `addr`, `size`, `wstrb`, `wdata`, then go to `WR_REQ` if `data_wr`, else `RD_AR`.
- `RD_AR`:
  - `arvalid = 1`, with `araddr`/`arsize` taken from the latches.
  - On `arready`, go to `RD_R`.
- `RD_R`:
  - `rready = 1`.
  - On `rvalid`, register `rdata` into `data_rdata` and set `data_data_ok` for the next cycle; go to `IDLE`.
- `WR_REQ`:
  - `awvalid` and `wvalid` are both raised on entry.
  - Each one drops independently after its own handshake; track this with `aw_done` and `w_done` flags.
  - Go to `WR_B` when both are done, including the case where both handshakes happen in the same cycle.
- `WR_B`:
  - `bready = 1`.
  - On `bvalid`, set `data_data_ok` for the next cycle; go to `IDLE`.
  - `bresp`/`rresp` are ignored.
- `data_data_ok` is a registered pulse, high for exactly one cycle per accepted request.
- `data_data_ok` and `data_addr_ok` may be high in the same cycle: the completion cycle is already `IDLE`, so a new request can be accepted there.
- Outside the states named above, all AXI valid/ready outputs are 0.
- AXI address, size, data and strobe outputs come from the latches and stay stable while their valid is high.

## Timing

- Reset values:
  - state = `IDLE`.
  - `arvalid`, `rready`, `awvalid`, `wvalid`, `bready`, `data_data_ok` = 0.
  - `data_rdata`, latched addr/data = 0.
  - `data_addr_ok` follows `data_req` immediately after reset.
- Minimum read latency, with `arready` held high and `rvalid` returned one cycle after the AR handshake:
  - accept at cycle 0; AR handshake at cycle 1; R at cycle 2; `data_data_ok` at cycle 3.
- Minimum write latency, with AW, W and B all ready immediately:
  - accept at cycle 0; AW+W at cycle 1; B at cycle 2; `data_data_ok` at cycle 3.
- `data_req` is ignored in every state except `IDLE`.
- Reset asserted mid-transaction:
  - all outputs return to reset values asynchronously.
  - no `data_data_ok` is issued for the aborted request.

## Test plan

- Read: `data_req=1`, `data_wr=0`, `addr=0x1FAF_F000`, size 2; slave returns `0xDEADBEEF` after 3 cycles.
  - Expect `arvalid` held until `arready`, `araddr=0x1FAF_F000`, `arsize=2`, then one `data_data_ok` pulse with `data_rdata=0xDEADBEEF`.
- Write, W before AW: wstrb `4'b0011`, wdata `0x0000_1234`, addr `0x1FAF_F008`; `wready` at cycle 1, `awready` at cycle 3.
  - Expect `wvalid` to drop after cycle 1, `awvalid` to drop after cycle 3, `bready` from cycle 4, and `data_data_ok` exactly one cycle after `bvalid`.
- Back-to-back: a read followed by a write requested in the `data_data_ok` cycle.
  - Expect `data_addr_ok=1` in that same cycle and the AW/W issued on the next cycle.
- Busy hold-off: `data_req` held high during an outstanding read.
  - Expect `data_addr_ok=0` until `IDLE`, and exactly one pulse per accepted request (count 10 random requests → 10 pulses).
- Reset mid-write: assert `reset` while in `WR_B`.
  - Expect `bready=0`, `data_data_ok=0` and state `IDLE` without waiting for a clock edge.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/uncached_data_bridge.sv
// ============================================================================
// Module   : uncached_data_bridge
// Purpose  : Converts the core's SRAM-like data port into single-beat AXI
//            reads and writes for uncached accesses. Exactly one transaction
//            is outstanding at a time, and each one completes with a
//            registered one-cycle data_data_ok pulse.
// Ports    : clk, reset (async, active-high)
//            Core side : data_req, data_wr, data_size, data_wstrb, data_addr,
//                        data_wdata -> data_addr_ok, data_data_ok, data_rdata
//            AXI AR/R  : araddr, arsize, arvalid, arready, rdata, rvalid,
//                        rready
//            AXI AW/W/B: awaddr, awsize, awvalid, awready, wdata, wstrb,
//                        wvalid, wready, bvalid, bready
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uncached_data_bridge (
    input  logic        clk,
    input  logic        reset,
    // core data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address / data
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address / data / response
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_REQ = 3'd3,
        WR_B   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_data_ok;

    logic        w_accept;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_r_hs;
    logic        w_b_hs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        case (r_state)
            IDLE: begin
                data_addr_ok = data_req;
                if (data_req) begin
                    w_state_next = data_wr ? WR_REQ : RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_next = RD_R;
                end
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_state_next = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; a channel whose handshake
                // already happened counts as done, so both finishing in the
                // same cycle also advances.
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if ((r_aw_done || awready) && (r_w_done || wready)) begin
                    w_state_next = WR_B;
                end
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept = data_addr_ok;
    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid & wready;
    assign w_r_hs   = rready & rvalid;
    assign w_b_hs   = bready & bvalid;

    // ------------------------------------------------------------------
    // Request latches, channel-done flags, read data and completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= 32'd0;
            r_size    <= 3'd0;
            r_wstrb   <= 4'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_data_ok <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= data_addr;
                r_size    <= data_size;
                r_wstrb   <= data_wstrb;
                r_wdata   <= data_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end

            if (w_r_hs) begin
                r_rdata <= rdata;
            end

            r_data_ok <= w_r_hs | w_b_hs;
        end
    end

    assign araddr       = r_addr;
    assign arsize       = r_size;
    assign awaddr       = r_addr;
    assign awsize       = r_size;
    assign wdata        = r_wdata;
    assign wstrb        = r_wstrb;
    assign data_rdata   = r_rdata;
    assign data_data_ok = r_data_ok;

endmodule

`default_nettype wire

// File: tb/tb_uncached_data_bridge.sv
// ============================================================================
// Module   : tb_uncached_data_bridge
// Purpose  : Self-checking bench for uncached_data_bridge. A cycle-based
//            AXI slave model with programmable ready/valid delays answers
//            the bridge; accepted requests are pushed onto a scoreboard and
//            popped when data_data_ok pulses.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uncached_data_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_req;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    uncached_data_bridge u_dut (
        .clk          (clk),
        .reset        (reset),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    // slave model configuration and state
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit          r_pend, b_pend, aw_got, w_got;
    logic [31:0] r_val;

    // event bookkeeping
    bit          acc_flag;
    bit          tb_aw_hs, tb_w_hs;
    int          t_acc, t_ar, t_r, t_aw, t_w, t_b, t_ok, t_bready;
    int          n_acc = 0;
    int          n_ok = 0;
    int          ar_cycles;
    int          base_ok, base_acc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_value(input logic [31:0] a);
        if (a == 32'h1FAF_F000) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic slave_clear();
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = 32'd0;
    endtask

    // One clock cycle: slave drives at the falling edge, everything is
    // sampled 1ns later, and control returns 1ns after the next rising edge.
    task automatic cycle();
        txn_t t;
        logic exp_ok;
        @(negedge clk);
        arready = arvalid && (ar_cnt >= ar_dly);
        awready = awvalid && (aw_cnt >= aw_dly);
        wready  = wvalid  && (w_cnt  >= w_dly);
        rvalid  = r_pend  && (r_cnt  >= r_dly);
        rdata   = rvalid ? r_val : $urandom;
        bvalid  = b_pend  && (b_cnt  >= b_dly);
        #1;
        acc_flag = 0;

        // completion
        if (data_data_ok) begin
            n_ok++;
            t_ok = cyc;
            check("ok_has_txn", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                if (!t.wr) check("data_rdata", data_rdata, t.rdata);
            end
        end

        // AXI channel contents against the outstanding request
        if (sb.size() == 0)
            check("axi_quiet", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        if (arvalid) begin
            ar_cycles++;
            check("ar_pending", 32'(sb.size() == 1 && !sb[0].wr), 32'd1);
            if (sb.size() != 0) begin
                check("araddr", araddr, sb[0].addr);
                check("arsize", 32'(arsize), 32'(sb[0].size));
            end
        end
        if (awvalid) begin
            check("awvalid_drop", 32'(tb_aw_hs), 32'd0);
            if (sb.size() != 0) begin
                check("awaddr", awaddr, sb[0].addr);
                check("awsize", 32'(awsize), 32'(sb[0].size));
            end
        end
        if (wvalid) begin
            check("wvalid_drop", 32'(tb_w_hs), 32'd0);
            if (sb.size() != 0) begin
                check("wdata", wdata, sb[0].wdata);
                check("wstrb", 32'(wstrb), 32'(sb[0].wstrb));
            end
        end
        if (bready && t_bready < 0) t_bready = cyc;

        // acceptance: only possible when nothing is outstanding
        exp_ok = data_req && (sb.size() == 0);
        check("addr_ok", 32'(data_addr_ok), 32'(exp_ok));
        if (data_req && data_addr_ok) begin
            t.wr    = data_wr;
            t.addr  = data_addr;
            t.size  = data_size;
            t.wstrb = data_wstrb;
            t.wdata = data_wdata;
            t.rdata = rd_value(data_addr);
            sb.push_back(t);
            n_acc++;
            t_acc     = cyc;
            acc_flag  = 1;
            tb_aw_hs  = 0;
            tb_w_hs   = 0;
            t_bready  = -1;
            ar_cycles = 0;
        end

        // slave handshakes take effect at the coming rising edge
        if (b_pend) begin
            if (bvalid && bready) begin b_pend = 0; t_b = cyc; end
            else b_cnt++;
        end
        if (r_pend) begin
            if (rvalid && rready) begin r_pend = 0; t_r = cyc; end
            else r_cnt++;
        end
        if (arvalid && arready) begin
            r_pend = 1; r_cnt = 0; r_val = rd_value(araddr); ar_cnt = 0; t_ar = cyc;
        end else if (arvalid) ar_cnt++;
        if (awvalid && awready) begin
            aw_got = 1; tb_aw_hs = 1; aw_cnt = 0; t_aw = cyc;
        end else if (awvalid) aw_cnt++;
        if (wvalid && wready) begin
            w_got = 1; tb_w_hs = 1; w_cnt = 0; t_w = cyc;
        end else if (wvalid) w_cnt++;
        if (aw_got && w_got) begin
            b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents a request and holds it until accepted; data_req stays high.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] strb, input logic [31:0] wd);
        data_req   = 1'b1;
        data_wr    = wr;
        data_addr  = addr;
        data_size  = size;
        data_wstrb = strb;
        data_wdata = wd;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (acc_flag) return;
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) return;
            cycle();
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic set_delays(input int a, input int r, input int aw, input int w, input int b);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    initial begin
        reset = 1'b1;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0;
        tb_aw_hs = 0; tb_w_hs = 0; t_bready = -1; ar_cycles = 0;
        t_acc = 0; t_ar = 0; t_r = 0; t_aw = 0; t_w = 0; t_b = 0; t_ok = 0;
        set_delays(0, 0, 0, 0, 0);
        slave_clear();

        // reset values
        #3;
        check("rst_axi_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("rst_data_ok", 32'(data_data_ok), 32'd0);
        check("rst_rdata", data_rdata, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        data_req = 1'b1;
        #1;
        check("rst_addr_ok_follow_hi", 32'(data_addr_ok), 32'd1);
        data_req = 1'b0;
        #1;
        check("rst_addr_ok_follow_lo", 32'(data_addr_ok), 32'd0);

        // read with wait states on AR and R
        set_delays(2, 2, 0, 0, 0);
        issue(1'b0, 32'h1FAF_F000, 3'd2, 4'hF, 32'd0);
        data_req = 1'b0;
        drain();
        check("rd_ar_hold_cycles", 32'(ar_cycles), 32'd3);
        check("rd_ok_after_r", 32'(t_ok - t_r), 32'd1);
        check("rd_rdata_value", data_rdata, 32'hDEAD_BEEF);

        // minimum read latency
        set_delays(0, 0, 0, 0, 0);
        issue(1'b0, 32'h1000_0041, 3'd0, 4'h0, 32'd0);
        data_req = 1'b0;
        drain();
        check("rd_min_ar", 32'(t_ar - t_acc), 32'd1);
        check("rd_min_ok", 32'(t_ok - t_acc), 32'd3);

        // minimum write latency
        issue(1'b1, 32'h1000_0080, 3'd2, 4'hF, 32'hCAFE_F00D);
        data_req = 1'b0;
        drain();
        check("wr_min_aw", 32'(t_aw - t_acc), 32'd1);
        check("wr_min_w", 32'(t_w - t_acc), 32'd1);
        check("wr_min_ok", 32'(t_ok - t_acc), 32'd3);
        check("rdata_held_after_wr", data_rdata, rd_value(32'h1000_0041));

        // write with W before AW
        set_delays(0, 0, 2, 0, 0);
        issue(1'b1, 32'h1FAF_F008, 3'd1, 4'b0011, 32'h0000_1234);
        data_req = 1'b0;
        drain();
        check("wfirst_w_hs", 32'(t_w - t_acc), 32'd1);
        check("wfirst_aw_hs", 32'(t_aw - t_acc), 32'd3);
        check("wfirst_bready", 32'(t_bready - t_acc), 32'd4);
        check("wfirst_ok_after_b", 32'(t_ok - t_b), 32'd1);

        // back-to-back: write presented while read is outstanding
        set_delays(0, 1, 0, 0, 0);
        issue(1'b0, 32'h2000_0100, 3'd2, 4'hF, 32'd0);
        issue(1'b1, 32'h2000_0104, 3'd2, 4'b1100, 32'h5566_7788);
        check("b2b_accept_in_ok_cycle", 32'(t_acc), 32'(t_ok));
        data_req = 1'b0;
        drain();
        check("b2b_aw_next", 32'(t_aw - t_acc), 32'd1);
        check("b2b_w_next", 32'(t_w - t_acc), 32'd1);
        check("b2b_rdata_held", data_rdata, rd_value(32'h2000_0100));

        // busy hold-off: 10 random requests held continuously
        base_ok  = n_ok;
        base_acc = n_acc;
        for (int i = 0; i < 10; i++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} ^ 32'h1000_0000,
                  3'($urandom_range(0, 2)), 4'($urandom), $urandom);
        end
        data_req = 1'b0;
        drain();
        check("busy_accepts", 32'(n_acc - base_acc), 32'd10);
        check("busy_pulses", 32'(n_ok - base_ok), 32'd10);

        // reset in WR_B
        set_delays(0, 0, 0, 0, 6);
        issue(1'b1, 32'h3000_0010, 3'd2, 4'hF, 32'h0BAD_0BAD);
        data_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (t_bready >= 0) break;
        end
        check("rstmid_reached_wr_b", 32'(t_bready >= 0), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_bready", 32'(bready), 32'd0);
        check("rstmid_data_ok", 32'(data_data_ok), 32'd0);
        check("rstmid_valids", 32'({arvalid, rready, awvalid, wvalid}), 32'd0);
        check("rstmid_rdata", data_rdata, 32'd0);
        data_req = 1'b1;
        #1;
        check("rstmid_idle", 32'(data_addr_ok), 32'd1);
        data_req = 1'b0;
        sb.delete();
        slave_clear();
        cycle();
        cycle();
        reset = 1'b0;
        set_delays(0, 0, 0, 0, 0);
        base_ok = n_ok;
        issue(1'b0, 32'h1FAF_F000, 3'd2, 4'hF, 32'd0);
        data_req = 1'b0;
        drain();
        check("post_rst_pulses", 32'(n_ok - base_ok), 32'd1);
        check("post_rst_rdata", data_rdata, 32'hDEAD_BEEF);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
